mips_boot_loader: RTL and testbench

Parametrised program loader and run monitor for the pipelined MIPS32 core. It streams a program into the core's unified memory at a chosen base address and releases the core from reset. It then counts cycles until HALT or a timeout, and reads back a block of data words as a stream. This replaces hand-poked memory initialisation with a synthesisable, reusable harness block usable in simulation and on FPGA.

---
 rtl/mips_boot_loader.sv | 191 +++++++++++++++++++
 tb/tb_mips_boot_loader.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_boot_loader.sv
// mips_boot_loader: program loader and run monitor for the pipelined MIPS32 core.
// Streams a program into unified memory, releases the core, counts RUN cycles
// until HALT or timeout, then streams a block of memory words back out.
//
// Ports:
//   clk1, rst_n             single clock, synchronous active-low reset
//   start                   begin load/run/dump (sampled in IDLE/DONE only)
//   prog_base, prog_len     program placement and length (clamped to PROG_DEPTH)
//   dump_base               first read-back word address
//   s_valid/s_ready/s_data  program word stream in
//   mem_we/addr/wdata/rdata loader side of the memory mux (rdata has 1-cycle latency)
//   core_rst_n, core_halted core reset release and halt flag
//   m_valid/m_ready/m_data/m_last  read-back stream out
//   busy, done, timed_out, cycle_count  status of the last run
module mips_boot_loader #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned PROG_DEPTH = 64,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned DUMP_WORDS = 4,
  localparam int unsigned LEN_W     = $clog2(PROG_DEPTH) + 1
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] prog_base,
  input  logic [LEN_W-1:0]  prog_len,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_rst_n,
  input  logic              core_halted,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic              timed_out,
  output logic [31:0]       cycle_count
);

  localparam int unsigned J_W = $clog2(DUMP_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DUMP_RD,
    S_DUMP_WAIT,
    S_DUMP_OUT,
    S_DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] dbase_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;
  logic [J_W-1:0]    j_q;
  logic [LEN_W-1:0]  clamp_len;
  logic [LEN_W-1:0]  idx_inc;
  logic [31:0]       cnt_inc;

  assign clamp_len = (prog_len > LEN_W'(PROG_DEPTH)) ? LEN_W'(PROG_DEPTH) : prog_len;
  assign idx_inc   = idx_q + LEN_W'(1);
  assign cnt_inc   = cycle_count + 32'd1;

  // Load handshake is combinational so the last word is written before the
  // core takes the memory; mem_we can never coincide with core_rst_n=1.
  assign s_ready   = (state == S_LOAD);
  assign mem_we    = s_ready & s_valid;
  assign mem_wdata = mem_we ? s_data : '0;

  // Loader address: program slot while loading, dump slot while reading back.
  always_comb begin
    mem_addr = '0;
    case (state)
      S_LOAD:    mem_addr = base_q + ADDR_W'(idx_q);
      S_DUMP_RD: mem_addr = dbase_q + ADDR_W'(j_q);
      default:   mem_addr = '0;
    endcase
  end

  // Control FSM with its registered outputs and counters.
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      base_q      <= '0;
      dbase_q     <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      j_q         <= '0;
      core_rst_n  <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            base_q      <= prog_base;
            dbase_q     <= dump_base;
            len_q       <= clamp_len;
            idx_q       <= '0;
            j_q         <= '0;
            timed_out   <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
            busy        <= 1'b1;
            if (clamp_len == '0) begin
              state      <= S_RUN;
              core_rst_n <= 1'b1;
            end else begin
              state <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (s_valid) begin
            idx_q <= idx_inc;
            if (idx_inc == len_q) begin
              state      <= S_RUN;
              core_rst_n <= 1'b1;
            end
          end
        end

        // Halt takes priority over counting, so a halt on the cycle that
        // would have hit the limit is not reported as a timeout.
        S_RUN: begin
          if (core_halted) begin
            state      <= S_DUMP_RD;
            core_rst_n <= 1'b0;
            j_q        <= '0;
          end else begin
            cycle_count <= cnt_inc;
            if (cnt_inc == 32'(TIMEOUT)) begin
              timed_out  <= 1'b1;
              state      <= S_DUMP_RD;
              core_rst_n <= 1'b0;
              j_q        <= '0;
            end
          end
        end

        S_DUMP_RD: begin
          state <= S_DUMP_WAIT;
        end

        S_DUMP_WAIT: begin
          m_data  <= mem_rdata;
          m_valid <= 1'b1;
          m_last  <= (j_q == J_W'(DUMP_WORDS - 1));
          state   <= S_DUMP_OUT;
        end

        // m_data/m_last only change after an accepted beat.
        S_DUMP_OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (m_last) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              j_q   <= j_q + J_W'(1);
              state <= S_DUMP_RD;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_boot_loader.sv
// Self-checking bench for mips_boot_loader: randomized transactions checked
// against a memory-array reference model of load, run and dump.
module tb_mips_boot_loader;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned PROG_DEPTH = 8;
  localparam int unsigned TIMEOUT    = 40;
  localparam int unsigned DUMP_WORDS = 2;
  localparam int unsigned LEN_W      = $clog2(PROG_DEPTH) + 1;
  localparam int unsigned MEM_N      = 1 << ADDR_W;

  logic              clk1 = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] prog_base = '0;
  logic [LEN_W-1:0]  prog_len = '0;
  logic [ADDR_W-1:0] dump_base = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              core_rst_n;
  logic              core_halted = 1'b0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              busy;
  logic              done;
  logic              timed_out;
  logic [31:0]       cycle_count;

  mips_boot_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PROG_DEPTH(PROG_DEPTH),
    .TIMEOUT(TIMEOUT), .DUMP_WORDS(DUMP_WORDS)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .start(start),
    .prog_base(prog_base), .prog_len(prog_len), .dump_base(dump_base),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .core_rst_n(core_rst_n), .core_halted(core_halted),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .timed_out(timed_out), .cycle_count(cycle_count)
  );

  always #5 clk1 = ~clk1;

  // Synchronous memory seen by the loader (read-before-write, 1-cycle latency).
  logic [DATA_W-1:0] mem [MEM_N];
  logic [DATA_W-1:0] ref_mem [MEM_N];
  logic [DATA_W-1:0] prog [16];

  always @(posedge clk1) begin
    logic [DATA_W-1:0] rd;
    rd = mem[mem_addr];
    if (mem_we) mem[mem_addr] = mem_wdata;
    mem_rdata <= rd;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Observers: memory writes, accepted read-back beats, hold-while-stalled.
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t             wr_q[$];
  logic [DATA_W:0] out_q[$];
  int              cyc = 0;
  int              first_wr = 0;
  int              last_wr = 0;
  bit              own_viol = 0;
  bit              we_noval = 0;
  logic            pv = 1'b0;
  logic            pr = 1'b0;
  logic            pl = 1'b0;
  logic [DATA_W-1:0] pd = '0;

  always @(posedge clk1) cyc++;

  always @(negedge clk1) begin
    wr_t w;
    if (mem_we) begin
      w.a = mem_addr;
      w.d = mem_wdata;
      wr_q.push_back(w);
      if (wr_q.size() == 1) first_wr = cyc;
      last_wr = cyc;
      if (core_rst_n) own_viol = 1;
      if (!s_valid) we_noval = 1;
    end
    if (m_valid && m_ready) out_q.push_back({m_last, m_data});
    if (pv && !pr && rst_n) begin
      check("hold_valid", 64'(m_valid), 64'd1);
      check("hold_data", 64'(m_data), 64'(pd));
      check("hold_last", 64'(m_last), 64'(pl));
    end
    pv = m_valid;
    pr = m_ready;
    pd = m_data;
    pl = m_last;
  end

  // One full load/run/dump; gap_mode 0=back-to-back 1=two idle cycles 2=random,
  // ready_mode 0=always 1=random 2=held low 5 cycles per beat.
  task automatic run_txn(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] plen,
                         input logic [ADDR_W-1:0] dbase, input int gap_mode,
                         input int halt_after, input int ready_mode, input bit start_in_run);
    int eff, k, vcnt, exp_cnt, exp_runs, g;
    bit exp_to, left, fin;
    logic [DATA_W:0] exp_beat;

    eff      = (int'(plen) > int'(PROG_DEPTH)) ? int'(PROG_DEPTH) : int'(plen);
    for (int i = 0; i < eff; i++) ref_mem[(int'(base) + i) % MEM_N] = prog[i];
    exp_to   = (halt_after >= int'(TIMEOUT));
    exp_cnt  = exp_to ? int'(TIMEOUT) : halt_after;
    exp_runs = exp_to ? int'(TIMEOUT) : halt_after + 1;

    wr_q.delete();
    out_q.delete();
    own_viol = 0;
    we_noval = 0;

    prog_base = base;
    prog_len  = plen;
    dump_base = dbase;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("done_cleared", 64'(done), 64'd0);
    check("timed_out_cleared", 64'(timed_out), 64'd0);
    check("count_cleared", 64'(cycle_count), 64'd0);
    if (eff == 0) check("run_after_start", 64'(core_rst_n), 64'd1);
    else          check("s_ready_in_load", 64'(s_ready), 64'd1);

    for (int i = 0; i < eff; i++) begin
      g = (gap_mode == 1) ? ((i == 0) ? 0 : 2) :
          (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      for (int n = 0; n < g; n++) begin
        s_valid = 1'b0;
        tick();
      end
      s_valid = 1'b1;
      s_data  = prog[i];
      tick();
    end

    // A surplus word offered after the load must be ignored.
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    k = 0;
    left = 0;
    for (int c = 0; c < int'(TIMEOUT) + 60 && !left; c++) begin
      if (c == 1) s_valid = 1'b0;
      if (core_rst_n) begin
        k++;
        core_halted = (k > halt_after);
        start = start_in_run && (k == 5);
      end else if (k > 0) begin
        left = 1;
      end
      if (!left) tick();
    end
    s_valid = 1'b0;
    core_halted = 1'b0;
    start = 1'b0;
    check("run_exit", 64'(left), 64'd1);
    check("run_cycles", 64'(k), 64'(exp_runs));

    fin = 0;
    vcnt = 0;
    for (int c = 0; c < 40 * int'(DUMP_WORDS) && !fin; c++) begin
      if (done) begin
        fin = 1;
      end else begin
        vcnt = m_valid ? vcnt + 1 : 0;
        m_ready = (ready_mode == 0) ? 1'b1 :
                  (ready_mode == 1) ? 1'($urandom_range(0, 1)) : (vcnt > 5);
        tick();
      end
    end
    m_ready = 1'b0;

    check("dump_finished", 64'(fin), 64'd1);
    check("done", 64'(done), 64'd1);
    check("busy_in_done", 64'(busy), 64'd0);
    check("core_rst_n_after", 64'(core_rst_n), 64'd0);
    check("timed_out", 64'(timed_out), 64'(exp_to));
    check("cycle_count", 64'(cycle_count), 64'(exp_cnt));

    check("write_count", 64'(wr_q.size()), 64'(eff));
    for (int i = 0; i < eff && i < wr_q.size(); i++) begin
      check("write_addr", 64'(wr_q[i].a), 64'((int'(base) + i) % MEM_N));
      check("write_data", 64'(wr_q[i].d), 64'(prog[i]));
    end
    if (gap_mode == 0 && eff > 1) check("write_spacing", 64'(last_wr - first_wr), 64'(eff - 1));
    if (gap_mode == 1 && eff > 1) check("write_spacing", 64'(last_wr - first_wr), 64'(3 * (eff - 1)));
    check("mem_ownership", 64'(own_viol), 64'd0);
    check("write_needs_valid", 64'(we_noval), 64'd0);

    check("dump_count", 64'(out_q.size()), 64'(DUMP_WORDS));
    for (int j = 0; j < int'(DUMP_WORDS) && j < out_q.size(); j++) begin
      exp_beat = {1'(j == int'(DUMP_WORDS) - 1), ref_mem[(int'(dbase) + j) % MEM_N]};
      check("dump_beat", 64'(out_q[j]), 64'(exp_beat));
    end

    tick();
    tick();
    check("count_held", 64'(cycle_count), 64'(exp_cnt));
    check("done_held", 64'(done), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_we"}, 64'(mem_we), 64'd0);
    check({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_core_rst_n"}, 64'(core_rst_n), 64'd0);
    check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_m_last"}, 64'(m_last), 64'd0);
    check({tag, "_m_data"}, 64'(m_data), 64'd0);
    check({tag, "_timed_out"}, 64'(timed_out), 64'd0);
    check({tag, "_cycle_count"}, 64'(cycle_count), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
  endtask

  // Reset asserted after the third of eight program words.
  task automatic reset_mid_load();
    logic [ADDR_W-1:0] base;
    base = ADDR_W'($urandom);
    for (int i = 0; i < 8; i++) prog[i] = $urandom;
    for (int i = 0; i < 3; i++) ref_mem[(int'(base) + i) % MEM_N] = prog[i];
    wr_q.delete();
    prog_base = base;
    prog_len  = LEN_W'(8);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = prog[i];
      tick();
    end
    s_valid = 1'b0;
    rst_n   = 1'b0;
    tick();
    check_idle_outputs("reset_mid_load");
    s_valid = 1'b1;
    s_data  = 32'hBAD0_0000;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    s_valid = 1'b0;
    check("reset_write_count", 64'(wr_q.size()), 64'd3);
    for (int i = 0; i < 3 && i < wr_q.size(); i++)
      check("reset_write_addr", 64'(wr_q[i].a), 64'((int'(base) + i) % MEM_N));
    check("reset_idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    int gm, rm, ha;
    logic [ADDR_W-1:0] b, db;
    logic [LEN_W-1:0]  pl_r;

    for (int i = 0; i < int'(MEM_N); i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[120] = 32'd85;  ref_mem[120] = 32'd85;
    mem[121] = 32'd130; ref_mem[121] = 32'd130;

    rst_n = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    tick();

    // Directed program, halt after 30 RUN cycles, dump Mem[120..121].
    prog[0] = 32'h2801_0078; prog[1] = 32'h0c63_1800;
    prog[2] = 32'h2022_0000; prog[3] = 32'h0c63_1800;
    prog[4] = 32'h2842_002d; prog[5] = 32'h0c63_1800;
    prog[6] = 32'h2422_0001; prog[7] = 32'hfc00_0000;
    run_txn(10'd0, LEN_W'(8), 10'd120, 0, 30, 0, 0);

    // s_valid pattern 1,0,0,1,... with dump reading the program back.
    for (int i = 0; i < 16; i++) prog[i] = $urandom;
    run_txn(10'd200, LEN_W'(5), 10'd203, 1, 10, 1, 0);

    // Core never halts: timeout, dump still runs.
    for (int i = 0; i < 16; i++) prog[i] = $urandom;
    run_txn(10'd300, LEN_W'(3), 10'd301, 0, 100000, 1, 0);

    // Empty program goes straight to RUN.
    run_txn(10'd500, LEN_W'(0), 10'd7, 0, 4, 0, 0);

    // Address wrap on load and dump.
    for (int i = 0; i < 16; i++) prog[i] = $urandom;
    run_txn(10'd1022, LEN_W'(4), 10'd1023, 0, 12, 0, 0);

    // Sink stalls 5 cycles per beat.
    for (int i = 0; i < 16; i++) prog[i] = $urandom;
    run_txn(10'd40, LEN_W'(2), 10'd41, 2, 6, 2, 0);

    // Length above PROG_DEPTH is clamped.
    for (int i = 0; i < 16; i++) prog[i] = $urandom;
    run_txn(10'd600, LEN_W'(15), 10'd607, 0, 3, 0, 0);

    // start pulse during RUN is ignored.
    for (int i = 0; i < 16; i++) prog[i] = $urandom;
    run_txn(10'd700, LEN_W'(3), 10'd700, 0, 20, 0, 1);

    // Halt on the last cycle before the limit vs. exactly at the limit.
    run_txn(10'd710, LEN_W'(1), 10'd710, 0, int'(TIMEOUT) - 1, 0, 0);
    run_txn(10'd720, LEN_W'(1), 10'd720, 0, int'(TIMEOUT), 0, 0);

    reset_mid_load();

    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 16; i++) prog[i] = $urandom;
      b    = ADDR_W'($urandom);
      pl_r = LEN_W'($urandom_range(0, 15));
      db   = ($urandom_range(0, 1) == 1) ? b : ADDR_W'($urandom);
      gm   = int'($urandom_range(0, 2));
      rm   = int'($urandom_range(0, 2));
      ha   = int'($urandom_range(0, 50));
      run_txn(b, pl_r, db, gm, ha, rm, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
